// File: rtl/output_serializer_lanes.sv
// Fabric multi-lane parallel-to-serial output stage: words queue in a small FIFO and
// shift out one bit per lane on each clock_en strobe, padding with IDLE_PATTERN when starved.
module output_serializer_lanes #(
    parameter int                    NUM_LANES    = 4,
    parameter int                    DATA_WIDTH   = 4,
    parameter int                    FIFO_DEPTH   = 4,
    parameter bit                    MSB_FIRST    = 1'b0,
    parameter logic [DATA_WIDTH-1:0] IDLE_PATTERN = '0
) (
    input  logic                              clk_in,
    input  logic                              reset_n,
    input  logic                              clock_en,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]   data_in,
    input  logic                              data_valid,
    output logic                              data_ready,
    input  logic                              flush,
    input  logic                              underflow_clr,
    output logic [NUM_LANES-1:0]              data_out,
    output logic                              word_start,
    output logic                              underflow,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = NUM_LANES * DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;
    state_t r_state, w_state_next;

    logic [WW-1:0]        r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [AW:0]          r_level;
    logic [WW-1:0]        r_word;
    logic [CW-1:0]        r_bitcnt;
    logic [NUM_LANES-1:0] r_data_out;
    logic                 r_word_start;
    logic                 r_underflow;

    logic                 w_empty, w_full, w_write;
    logic                 w_boundary, w_load, w_pop, w_underflow_set;
    logic [WW-1:0]        w_load_word;
    logic [CW-1:0]        w_next_idx;

    // Picks the bit at shift-order position idx from every lane of a held word.
    function automatic logic [NUM_LANES-1:0] lane_bits(input logic [WW-1:0] word,
                                                       input logic [CW-1:0] idx);
        logic [NUM_LANES-1:0] bits;
        logic [CW-1:0]        pos;
        pos = MSB_FIRST ? LAST_BIT - idx : idx;
        for (int l = 0; l < NUM_LANES; l++) begin
            bits[l] = word[l*DATA_WIDTH + int'(pos)];
        end
        return bits;
    endfunction

    assign w_empty         = (r_level == '0);
    assign w_full          = (r_level == (AW+1)'(FIFO_DEPTH));
    assign data_ready      = !w_full && !flush;
    assign w_write         = data_valid && data_ready;
    assign w_boundary      = clock_en && (r_bitcnt == LAST_BIT);
    assign w_load          = w_boundary && !flush;
    assign w_pop           = w_load && !w_empty;
    assign w_underflow_set = w_load && w_empty && (r_state == S_RUN);
    assign w_load_word     = w_empty ? {NUM_LANES{IDLE_PATTERN}} : r_mem[r_rd_ptr];
    assign w_next_idx      = r_bitcnt + 1'b1;

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = S_IDLE;
        end else if (w_boundary) begin
            w_state_next = w_empty ? S_IDLE : S_RUN;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_write, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Starting at LAST_BIT makes the very first strobe a load, so words stay aligned.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_bitcnt     <= LAST_BIT;
            r_word       <= {NUM_LANES{IDLE_PATTERN}};
            r_data_out   <= '0;
            r_word_start <= 1'b0;
        end else if (flush) begin
            r_bitcnt     <= LAST_BIT;
            r_data_out   <= '0;
            r_word_start <= 1'b0;
        end else if (w_boundary) begin
            r_bitcnt     <= '0;
            r_word       <= w_load_word;
            r_data_out   <= lane_bits(w_load_word, '0);
            r_word_start <= !w_empty;
        end else if (clock_en) begin
            r_bitcnt     <= w_next_idx;
            r_data_out   <= lane_bits(r_word, w_next_idx);
            r_word_start <= 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_underflow <= 1'b0;
        end else if (w_underflow_set) begin
            r_underflow <= 1'b1;
        end else if (underflow_clr) begin
            r_underflow <= 1'b0;
        end
    end

    assign data_out   = r_data_out;
    assign word_start = r_word_start;
    assign underflow  = r_underflow;
    assign fifo_level = r_level;

endmodule

// File: tb/tb_output_serializer_lanes.sv
// Self-checking bench for output_serializer_lanes: an LSB-first instance with a 1010 idle
// pattern is tracked by a word scoreboard, and an MSB-first instance covers bit ordering.
module tb_output_serializer_lanes;
    localparam int NL = 4;
    localparam int DW = 4;
    localparam int WW = NL * DW;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          clockEn = 1'b0;
    logic          dataValid = 1'b0;
    logic          flush = 1'b0;
    logic          underflowClr = 1'b0;
    logic [WW-1:0] dataIn = '0;

    logic          aReady, aWordStart, aUnderflow;
    logic          bReady, bWordStart, bUnderflow;
    logic [NL-1:0] aDataOut, bDataOut;
    logic [2:0]    aLevel, bLevel;

    int            total = 0;
    int            bad = 0;
    logic [WW-1:0] sbQ[$];
    logic [WW-1:0] curWord;
    logic [NL-1:0] expBits;
    int            bitIdx = 0;
    bit            active = 1'b0;
    bit            strobeSeen = 1'b0;
    bit            flushSeen = 1'b0;
    logic [NL-1:0] t1Seq [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    output_serializer_lanes #(
        .NUM_LANES(NL), .DATA_WIDTH(DW), .FIFO_DEPTH(4),
        .MSB_FIRST(1'b0), .IDLE_PATTERN(4'b1010)
    ) dutA (
        .clk_in(clk), .reset_n(rstN), .clock_en(clockEn),
        .data_in(dataIn), .data_valid(dataValid), .data_ready(aReady),
        .flush(flush), .underflow_clr(underflowClr),
        .data_out(aDataOut), .word_start(aWordStart),
        .underflow(aUnderflow), .fifo_level(aLevel)
    );

    output_serializer_lanes #(
        .NUM_LANES(NL), .DATA_WIDTH(DW), .FIFO_DEPTH(4),
        .MSB_FIRST(1'b1), .IDLE_PATTERN(4'b0000)
    ) dutB (
        .clk_in(clk), .reset_n(rstN), .clock_en(clockEn),
        .data_in(dataIn), .data_valid(dataValid), .data_ready(bReady),
        .flush(flush), .underflow_clr(underflowClr),
        .data_out(bDataOut), .word_start(bWordStart),
        .underflow(bUnderflow), .fifo_level(bLevel)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [WW-1:0] word);
        dataIn    = word;
        dataValid = 1'b1;
        tick(1);
        dataValid = 1'b0;
    endtask

    task automatic waitWordStart(output int n);
        n = 0;
        while (!aWordStart && n < 12) begin
            tick(1);
            n++;
        end
    endtask

    // Accepted words enter the scoreboard; flush and reset discard everything pending.
    always @(posedge clk) begin
        strobeSeen = clockEn;
        flushSeen  = flush;
        if (flush) begin
            sbQ.delete();
            active = 1'b0;
        end else if (rstN && dataValid && aReady) begin
            sbQ.push_back(dataIn);
        end
    end

    always @(negedge rstN) begin
        sbQ.delete();
        active = 1'b0;
    end

    // After each strobe, a word_start pops the next expected word and its bits are compared in order.
    always @(negedge clk) begin
        if (rstN && strobeSeen && !flushSeen) begin
            if (aWordStart) begin
                checkOutput("sbWordAvailable", 32'(sbQ.size() != 0), 1);
                if (sbQ.size() != 0) begin
                    curWord = sbQ.pop_front();
                    bitIdx  = 0;
                    active  = 1'b1;
                end
            end else if (active) begin
                bitIdx++;
            end
            if (active) begin
                for (int l = 0; l < NL; l++) begin
                    expBits[l] = curWord[l*DW + bitIdx];
                end
                checkOutput("sbBit", aDataOut, expBits);
                if (bitIdx == DW - 1) begin
                    active = 1'b0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        $display("[TB] start");

        #12;
        checkOutput("rstDataOut", aDataOut, 0);
        checkOutput("rstWordStart", aWordStart, 0);
        checkOutput("rstUnderflow", aUnderflow, 0);
        checkOutput("rstLevel", aLevel, 0);
        checkOutput("rstReady", aReady, 1);
        checkOutput("rstDataOutB", bDataOut, 0);

        // Single word, continuous strobe.
        @(posedge clk);
        #1;
        rstN    = 1'b1;
        clockEn = 1'b1;
        applyStimulus(16'h8421);
        checkOutput("t1Level1", aLevel, 1);
        checkOutput("t1NoStart", aWordStart, 0);
        waitWordStart(n);
        checkOutput("t1Latency", n, 4);
        checkOutput("t1Level0", aLevel, 0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick(1);
            checkOutput("t1Data", aDataOut, t1Seq[k]);
            checkOutput("t1Start", aWordStart, k == 0);
        end
        tick(1);
        checkOutput("t1Underflow", aUnderflow, 1);
        checkOutput("t1IdleBit0", aDataOut, 0);

        // Fill without draining.
        clockEn      = 1'b0;
        underflowClr = 1'b1;
        tick(1);
        underflowClr = 1'b0;
        checkOutput("t2ClrUnderflow", aUnderflow, 0);
        for (int i = 0; i < 5; i++) begin
            dataIn    = 16'(16'hA5C3 + i * 16'h1357);
            dataValid = 1'b1;
            checkOutput("t2Ready", aReady, i < 4);
            tick(1);
        end
        checkOutput("t2Level4", aLevel, 4);
        checkOutput("t2ReadyLow", aReady, 0);
        checkOutput("t2ReadyLowB", bReady, 0);
        checkOutput("t2Level4B", bLevel, 4);

        // Drain, including the held fifth word, then starve.
        clockEn = 1'b1;
        n = 0;
        while (!aReady && n < 12) begin
            tick(1);
            n++;
        end
        checkOutput("t2ReadyReturns", aReady, 1);
        tick(1);
        dataValid = 1'b0;
        n = 0;
        while ((sbQ.size() != 0 || active) && n < 60) begin
            tick(1);
            n++;
        end
        checkOutput("t3Drained", n < 60, 1);
        n = 0;
        while (!aUnderflow && n < 8) begin
            tick(1);
            n++;
        end
        checkOutput("t3Underflow", aUnderflow, 1);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick(1);
            checkOutput("t3IdlePattern", aDataOut, (k % 2) ? 4'hF : 4'h0);
            checkOutput("t3Sticky", aUnderflow, 1);
            checkOutput("t3IdleNoStart", aWordStart, 0);
        end
        underflowClr = 1'b1;
        tick(1);
        underflowClr = 1'b0;
        checkOutput("t3Clr", aUnderflow, 0);

        // Clear held across the next underflow event: the set wins.
        applyStimulus(16'h2468);
        waitWordStart(n);
        checkOutput("t3NewWord", aWordStart, 1);
        underflowClr = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            checkOutput("t3ClrHeld", aUnderflow, 0);
        end
        tick(1);
        checkOutput("t3SetWins", aUnderflow, 1);
        tick(1);
        checkOutput("t3ClrAfter", aUnderflow, 0);
        underflowClr = 1'b0;

        // Flush mid-word with a pending write.
        clockEn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(16'(16'h0F0F + i * 16'h1111));
        end
        checkOutput("t5Level4", aLevel, 4);
        clockEn = 1'b1;
        waitWordStart(n);
        checkOutput("t5Loaded", aWordStart, 1);
        tick(2);
        checkOutput("t5Level3", aLevel, 3);
        flush     = 1'b1;
        dataValid = 1'b1;
        dataIn    = 16'hBEEF;
        #1;
        checkOutput("t5ReadyLow", aReady, 0);
        tick(1);
        flush     = 1'b0;
        dataValid = 1'b0;
        checkOutput("t5DataOut", aDataOut, 0);
        checkOutput("t5Level0", aLevel, 0);
        checkOutput("t5Level0B", bLevel, 0);
        checkOutput("t5WordStart", aWordStart, 0);
        checkOutput("t5Underflow", aUnderflow, 0);
        applyStimulus(16'h1357);
        waitWordStart(n);
        checkOutput("t5Realigned", n, 4);
        checkOutput("t5NoUnderflow", aUnderflow, 0);

        // Asynchronous reset mid-word.
        applyStimulus(16'hFFFF);
        checkOutput("t6LevelPre", aLevel, 1);
        #3;
        rstN = 1'b0;
        #1;
        checkOutput("t6DataOut", aDataOut, 0);
        checkOutput("t6WordStart", aWordStart, 0);
        checkOutput("t6Underflow", aUnderflow, 0);
        checkOutput("t6Level", aLevel, 0);
        checkOutput("t6Ready", aReady, 1);
        checkOutput("t6DataOutB", bDataOut, 0);
        tick(1);
        checkOutput("t6HeldLevel", aLevel, 0);
        rstN = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            checkOutput("t6Idle", aDataOut, (k % 2) ? 4'hF : 4'h0);
            checkOutput("t6NoGlitch", aWordStart, 0);
        end

        // Strobe every third cycle, MSB-first instance.
        clockEn = 1'b0;
        applyStimulus(16'h000F);
        checkOutput("t4Level", bLevel, 1);
        for (int j = 0; j < 15; j++) begin
            clockEn = (j % 3 == 0);
            tick(1);
            checkOutput("t4Lane", bDataOut, (j < 12) ? 4'b0001 : 4'b0000);
            checkOutput("t4Start", bWordStart, j < 3);
        end
        checkOutput("t4Underflow", bUnderflow, 1);
        tick(2);
        checkOutput("sbEmpty", sbQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
